// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle, signed or unsigned,
// result packed as {remainder, quotient} for HI/LO.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StDivZero = 2'd1;
    localparam logic [1:0] StOn      = 2'd2;
    localparam logic [1:0] StEnd     = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Holds |dividend| while dividing, shifting quotient bits in from the right;
    // holds the raw dividend on the divide-by-zero path.
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               dsr_neg_q, dsr_neg_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH:0]     rem_shift, trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_step, quo_step, rem_fix, quo_fix;

    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dsr_q};
        q_bit     = (rem_shift >= {1'b0, dsr_q});
        rem_step  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {dvd_q[WIDTH-2:0], q_bit};

        // Truncating division: quotient sign from operand signs, remainder follows dividend.
        quo_fix = (sgn_q && (dvd_neg_q ^ dsr_neg_q)) ? (~quo_step + 1'b1) : quo_step;
        rem_fix = (sgn_q && dvd_neg_q) ? (~rem_step + 1'b1) : rem_step;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        sgn_d     = sgn_q;
        result_d  = result_q;
        ready_d   = ready_q;
        busy_d    = busy_q;

        case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    busy_d = 1'b1;
                    if (opdata2_i == '0) begin
                        state_d = StDivZero;
                        dvd_d   = opdata1_i;
                    end else begin
                        state_d   = StOn;
                        dvd_d     = op1_abs;
                        dsr_d     = op2_abs;
                        rem_d     = '0;
                        cnt_d     = '0;
                        sgn_d     = signed_div_i;
                        dvd_neg_d = signed_div_i & opdata1_i[WIDTH-1];
                        dsr_neg_d = signed_div_i & opdata2_i[WIDTH-1];
                    end
                end
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        state_d  = StEnd;
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            StDivZero: begin
                busy_d = 1'b0;
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    state_d  = StEnd;
                    ready_d  = 1'b1;
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                end
            end
            StEnd: begin
                if (!start_i || annul_i) begin
                    state_d  = StIdle;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = StIdle;
                ready_d  = 1'b0;
                busy_d   = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            sgn_q     <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            sgn_q     <= sgn_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit and 8-bit instances, expected results queued at start.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s32_sgn = 1'b0, s32_start = 1'b0, s32_annul = 1'b0;
    logic [31:0] s32_a = '0, s32_b = '0;
    logic [63:0] s32_res;
    logic        s32_ready, s32_busy;

    logic        s8_sgn = 1'b0, s8_start = 1'b0, s8_annul = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic [15:0] s8_res;
    logic        s8_ready, s8_busy;

    logic [63:0] exp_q32[$];
    logic [15:0] exp_q8[$];

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(s32_sgn), .opdata1_i(s32_a), .opdata2_i(s32_b),
        .start_i(s32_start), .annul_i(s32_annul), .result_o(s32_res), .ready_o(s32_ready),
        .busy_o(s32_busy)
    );

    div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(s8_sgn), .opdata1_i(s8_a), .opdata2_i(s8_b),
        .start_i(s8_start), .annul_i(s8_annul), .result_o(s8_res), .ready_o(s8_ready),
        .busy_o(s8_busy)
    );

    // Reference in 64-bit arithmetic so the signed overflow case cannot trap.
    function automatic logic [63:0] model32(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic start32(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        @(negedge clk);
        s32_sgn = s; s32_a = a; s32_b = b; s32_start = 1'b1;
        exp_q32.push_back(exp);
    endtask

    task automatic start8(input bit s, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        @(negedge clk);
        s8_sgn = s; s8_a = a; s8_b = b; s8_start = 1'b1;
        exp_q8.push_back(exp);
    endtask

    task automatic wait32(output int cyc, output int bcyc, output bit both);
        cyc = 0; bcyc = 0; both = 1'b0;
        while (!s32_ready && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (s32_busy) bcyc++;
            if (s32_busy && s32_ready) both = 1'b1;
        end
    endtask

    task automatic wait8(output int cyc);
        cyc = 0;
        while (!s8_ready && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (s32_res !== 64'd0 || s32_ready !== 1'b0 || s32_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset32: got res=%h rdy=%b busy=%b expected all 0", s32_res, s32_ready, s32_busy);
        end
        checks++;
        if (s8_res !== 16'd0 || s8_ready !== 1'b0 || s8_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset8: got res=%h rdy=%b busy=%b expected all 0", s8_res, s8_ready, s8_busy);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        int cyc, bcyc;
        bit both;
        logic [63:0] exp;
        start32(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        wait32(cyc, bcyc, both);
        exp = exp_q32.pop_front();
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL u100_7_latency: got %0d expected 33", cyc); end
        checks++;
        if (bcyc !== 32 || both) begin
            errors++; $display("FAIL u100_7_busy: got %0d busy cycles, overlap=%b expected 32, 0", bcyc, both);
        end
        checks++;
        if (s32_res !== exp) begin errors++; $display("FAIL u100_7_result: got %h expected %h", s32_res, exp); end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (s32_ready !== 1'b1 || s32_res !== exp) begin
            errors++; $display("FAIL hold_ready: got rdy=%b res=%h expected 1 %h", s32_ready, s32_res, exp);
        end
        s32_start = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (s32_ready !== 1'b0 || s32_res !== 64'd0) begin
            errors++; $display("FAIL drop_start: got rdy=%b res=%h expected 0 0", s32_ready, s32_res);
        end

        // Operands scrambled after acceptance must not matter.
        start32(1'b0, 32'hFFFF_FFF9, 32'd2, 64'h00000001_7FFFFFFC);
        @(posedge clk); @(negedge clk);
        s32_a = 32'h0; s32_b = 32'h0; s32_sgn = 1'b1;
        wait32(cyc, bcyc, both);
        exp = exp_q32.pop_front();
        checks++;
        if (cyc !== 32 || s32_res !== exp) begin
            errors++; $display("FAIL ufff9_2: got cyc=%0d res=%h expected 32 %h", cyc, s32_res, exp);
        end
        s32_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_signed();
        int cyc, bcyc;
        bit both;
        logic [63:0] exp;
        start32(1'b1, -32'sd7, 32'sd2, 64'hFFFFFFFF_FFFFFFFD);
        wait32(cyc, bcyc, both);
        exp = exp_q32.pop_front();
        checks++;
        if (cyc !== 33 || s32_res !== exp) begin
            errors++; $display("FAIL s_m7_2: got cyc=%0d res=%h expected 33 %h", cyc, s32_res, exp);
        end
        s32_start = 1'b0;
        start32(1'b1, 32'sd7, -32'sd2, 64'h00000001_FFFFFFFD);
        wait32(cyc, bcyc, both);
        exp = exp_q32.pop_front();
        checks++;
        if (cyc !== 33 || s32_res !== exp) begin
            errors++; $display("FAIL s_7_m2: got cyc=%0d res=%h expected 33 %h", cyc, s32_res, exp);
        end
        s32_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_divzero();
        int cyc, bcyc;
        bit both;
        logic [63:0] exp;
        for (int s = 0; s < 2; s++) begin
            start32(s[0], 32'h1234_5678, 32'h0, 64'h12345678_FFFFFFFF);
            wait32(cyc, bcyc, both);
            exp = exp_q32.pop_front();
            checks++;
            if (cyc !== 2 || bcyc !== 1 || both) begin
                errors++;
                $display("FAIL divzero_timing s=%0d: got cyc=%0d busy=%0d expected 2 1", s, cyc, bcyc);
            end
            checks++;
            if (s32_res !== exp) begin
                errors++; $display("FAIL divzero_result s=%0d: got %h expected %h", s, s32_res, exp);
            end
            s32_start = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic test_overflow();
        int cyc, bcyc;
        bit both;
        logic [63:0] exp;
        start32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        wait32(cyc, bcyc, both);
        exp = exp_q32.pop_front();
        checks++;
        if (cyc !== 33 || s32_res !== exp) begin
            errors++; $display("FAIL overflow: got cyc=%0d res=%h expected 33 %h", cyc, s32_res, exp);
        end
        s32_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_annul();
        int cyc, bcyc;
        bit both, seen;
        logic [63:0] exp;
        @(negedge clk);
        s32_sgn = 1'b0; s32_a = 32'd1000; s32_b = 32'd7; s32_start = 1'b1;
        repeat (11) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (s32_busy !== 1'b1) begin errors++; $display("FAIL annul_pre_busy: got %b expected 1", s32_busy); end
        s32_annul = 1'b1; s32_start = 1'b0;
        @(posedge clk); @(negedge clk);
        s32_annul = 1'b0;
        checks++;
        if (s32_busy !== 1'b0 || s32_ready !== 1'b0) begin
            errors++; $display("FAIL annul_idle: got busy=%b rdy=%b expected 0 0", s32_busy, s32_ready);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); @(negedge clk); if (s32_ready || s32_busy) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL annul_no_result: got activity=1 expected 0"); end
        start32(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
        wait32(cyc, bcyc, both);
        exp = exp_q32.pop_front();
        checks++;
        if (cyc !== 33 || s32_res !== exp) begin
            errors++; $display("FAIL after_annul: got cyc=%0d res=%h expected 33 %h", cyc, s32_res, exp);
        end
        s32_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        s32_sgn = 1'b0; s32_a = 32'd50000; s32_b = 32'd3; s32_start = 1'b1;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (s32_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b expected 1", s32_busy); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (s32_busy !== 1'b0 || s32_ready !== 1'b0 || s32_res !== 64'd0) begin
            errors++;
            $display("FAIL arst_outputs: got busy=%b rdy=%b res=%h expected 0 0 0", s32_busy, s32_ready, s32_res);
        end
        s32_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_width8();
        int cyc;
        logic [15:0] exp;
        start8(1'b0, 8'd200, 8'd13, 16'h050F);
        wait8(cyc);
        exp = exp_q8.pop_front();
        checks++;
        if (cyc !== 9 || s8_res !== exp) begin
            errors++; $display("FAIL w8_200_13: got cyc=%0d res=%h expected 9 %h", cyc, s8_res, exp);
        end
        s8_start = 1'b0;
        start8(1'b1, 8'h80, 8'd3, 16'hFED6);
        wait8(cyc);
        exp = exp_q8.pop_front();
        checks++;
        if (cyc !== 9 || s8_res !== exp) begin
            errors++; $display("FAIL w8_m128_3: got cyc=%0d res=%h expected 9 %h", cyc, s8_res, exp);
        end
        s8_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc, want;
        bit both, s;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            start32(s, a, b, model32(s, a, b));
            wait32(cyc, bcyc, both);
            exp = exp_q32.pop_front();
            want = (b == 32'd0) ? 2 : 33;
            checks++;
            if (cyc !== want || s32_res !== exp || both) begin
                errors++;
                $display("FAIL b2b_%0d s=%0d %h/%h: got cyc=%0d res=%h expected %0d %h",
                         i, s, a, b, cyc, s32_res, want, exp);
            end
            // Single-cycle start gap between operations.
            s32_start = 1'b0;
            @(posedge clk); @(negedge clk);
            checks++;
            if (s32_ready !== 1'b0) begin errors++; $display("FAIL b2b_drop_%0d: got rdy=%b expected 0", i, s32_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_overflow();
        test_annul();
        test_async_reset();
        test_width8();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the MIPS pipeline's EX stage. It computes the quotient and remainder of a signed or unsigned division one bit per cycle and returns them as a packed {remainder, quotient} word for writing into HI/LO. While a division is in flight it asserts a busy flag that the pipeline uses as a stall request. EX can cancel the operation when the instruction is flushed.

## Interface
Parameters:
- WIDTH, 32: operand width in bits; legal values ≥ 2. Result is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- signed_div_i  input  1  1 = signed (two's complement) division; 0 = unsigned.
- opdata1_i  input  WIDTH  dividend; sampled only when a start is accepted.
- opdata2_i  input  WIDTH  divisor; sampled only when a start is accepted.
- start_i  input  1  request a division; level-held by EX until ready_o is seen.
- annul_i  input  1  cancel the current or pending division.
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- ready_o  output  1  result_o is valid.
- busy_o  output  1  division in progress (states ON, DIVZERO); used as the stall request.

## Operation
- States: IDLE, DIVZERO, ON, END. All outputs are registered.
- IDLE:
  - start_i=1 and annul_i=0 accepts a start.
  - If opdata2_i==0 → DIVZERO.
  - Otherwise → ON. Load |dividend| and |divisor| (absolute values only when signed_div_i=1), record both operand signs and signed_div_i, and clear the step counter cnt.
- ON: one restoring step per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - cnt increments after each step. The edge performing step WIDTH-1 also applies the sign fix-up, registers result_o, sets ready_o=1 and → END.
  - annul_i=1 in ON → IDLE on the next edge; no result is produced.
- Sign fix-up (signed only):
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend (truncating division).
- DIVZERO: next edge → END with quotient = all ones and remainder = the original opdata1_i; ready_o=1. This is the same in signed and unsigned mode. annul_i=1 → IDLE instead.
- END: ready_o=1 and result_o held.
  - start_i=0 or annul_i=1 → IDLE. On that edge ready_o=0 and result_o=0.
- Overflow: signed -2^(WIDTH-1) / -1 gives quotient -2^(WIDTH-1), remainder 0 (wraps naturally, no flag).
- start_i while in ON or DIVZERO is ignored. Operand changes after acceptance have no effect.
- Reset (rst=0, any time, including mid-operation): state IDLE; result_o=0, ready_o=0, busy_o=0; cnt and internal datapath cleared. The operation is lost.

## Timing
- A start is accepted at edge E0.
- Normal division: busy_o=1 from after E0 until E_WIDTH. ready_o rises after edge E_WIDTH, i.e. WIDTH+1 cycles after the request is sampled (33 cycles for WIDTH=32).
- Divide by zero: ready_o rises after E1 (2 cycles).
- ready_o and busy_o are never both 1.
- ready_o stays high for as long as start_i stays high; minimum 1 cycle.
- The earliest next start is accepted on the edge after returning to IDLE, so back-to-back divisions require start_i to drop for at least one cycle.
- annul_i takes effect on the next edge in every non-IDLE state. In IDLE it blocks acceptance for that cycle.
- cnt width is clog2(WIDTH+1); no wrap-around is possible because cnt is cleared on every accept.

## Test plan
- Unsigned, WIDTH=32: 100 / 7, start held → ready_o after 33 cycles, result_o = {0x00000002, 0x0000000E}; drop start → ready_o=0, result_o=0 next cycle.
- Signed: -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}; 7 / -2 → {0x00000001, 0xFFFFFFFD}. Unsigned 0xFFFFFFF9 / 2 → {0x00000001, 0x7FFFFFFC}.
- Divide by zero: 0x12345678 / 0 (signed and unsigned) → ready_o after 2 cycles, result_o = {0x12345678, 0xFFFFFFFF}. busy_o high for exactly 1 cycle.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000} after 33 cycles.
- Annul and reset:
  - Assert annul_i in cycle 10 of ON → IDLE, busy_o=0, ready_o never rises. A fresh 9 / 3 then returns {0, 3} correctly.
  - Drive rst=0 asynchronously mid-ON → all outputs 0 immediately.
- WIDTH=8 instance: unsigned 200 / 13 → {0x05, 0x0F} after 9 cycles. Signed -128 / 3 → {0xFE, 0xD6}.
